// File: rtl/ram_loader_pkg.sv
// Shared types and sizes for the program-RAM loader and the 16x8 program RAM.
package ram_loader_pkg;

  localparam int RAM_WORDS  = 16;
  localparam int RAM_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_CHECKSUM,
    S_VERIFY,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CHECKSUM = 2'd1,
    ERR_VERIFY   = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } error_code_t;

endpackage

// File: rtl/ram_loader_byte_checksum.sv
// 8-bit modular accumulator: clear wins over add, sum visible the cycle after add_en.
module byte_checksum
  import ram_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  add_en,
  input  logic [RAM_DATA_W-1:0] din,
  output logic [RAM_DATA_W-1:0] sum
);

  logic [RAM_DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add_en) begin
      sum_d = sum_q + din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/ram_loader.sv
// Streams 16 data bytes + checksum into the program RAM, reads them back and flags done/error.
// One data byte per two cycles at best; byte_ready drops during each RAM write and outside LOAD/CHECKSUM.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int WORDS          = RAM_WORDS,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int AW            = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [RAM_DATA_W-1:0] byte_data,
  output logic                  byte_ready,
  output logic                  ram_manual_mode,
  output logic                  ram_manual_read,
  output logic [AW-1:0]         ram_address,
  output logic [RAM_DATA_W-1:0] ram_program_data,
  input  logic [RAM_DATA_W-1:0] ram_data_in,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            error_code
);

  localparam int          TW   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] TLIM = 32'(TIMEOUT_CYCLES);

  state_t                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [TW-1:0]         tcnt_q, tcnt_d, tcnt_inc;
  logic                  byte_ready_q, byte_ready_d;
  logic                  manual_mode_q, manual_mode_d;
  logic                  manual_read_q, manual_read_d;
  logic [AW-1:0]         address_q, address_d;
  logic [RAM_DATA_W-1:0] program_data_q, program_data_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  error_code_t           err_code_q, err_code_d;

  logic                  sum_clr, load_add, read_add;
  logic [RAM_DATA_W-1:0] load_sum, read_sum, chk_sum, final_read_sum;
  logic                  handshake, last_idx, timed_out;

  byte_checksum u_load_sum (
    .clk    (clk),
    .rst    (rst),
    .clr    (sum_clr),
    .add_en (load_add),
    .din    (byte_data),
    .sum    (load_sum)
  );

  byte_checksum u_read_sum (
    .clk    (clk),
    .rst    (rst),
    .clr    (sum_clr),
    .add_en (read_add),
    .din    (ram_data_in),
    .sum    (read_sum)
  );

  always_comb begin
    handshake      = byte_valid && byte_ready_q;
    last_idx       = (idx_q == AW'(WORDS - 1));
    chk_sum        = load_sum + byte_data;
    final_read_sum = read_sum + ram_data_in;
    tcnt_inc       = (&tcnt_q) ? tcnt_q : tcnt_q + 1'b1;
    // Expires on the stalled cycle that brings the idle count up to the limit.
    timed_out      = (TIMEOUT_CYCLES != 0) && ((32'(tcnt_q) + 32'd1) >= TLIM);

    state_d        = state_q;
    idx_d          = idx_q;
    tcnt_d         = tcnt_q;
    address_d      = '0;
    program_data_d = '0;
    done_d         = done_q;
    error_d        = error_q;
    err_code_d     = err_code_q;
    sum_clr        = 1'b0;
    load_add       = 1'b0;
    read_add       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LOAD;
          idx_d      = '0;
          tcnt_d     = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          sum_clr    = 1'b1;
        end
      end
      S_LOAD: begin
        if (handshake) begin
          state_d        = S_WRITE;
          load_add       = 1'b1;
          tcnt_d         = '0;
          address_d      = idx_q;
          program_data_d = byte_data;
        end else if (timed_out) begin
          state_d    = S_ERROR;
          error_d    = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      S_WRITE: begin
        if (last_idx) begin
          state_d = S_CHECKSUM;
        end else begin
          state_d = S_LOAD;
          idx_d   = idx_q + 1'b1;
        end
      end
      S_CHECKSUM: begin
        if (handshake) begin
          tcnt_d = '0;
          if (chk_sum == '0) begin
            state_d = S_VERIFY;
            idx_d   = '0;
          end else begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            err_code_d = ERR_CHECKSUM;
          end
        end else if (timed_out) begin
          state_d    = S_ERROR;
          error_d    = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      S_VERIFY: begin
        read_add = 1'b1;
        if (last_idx) begin
          if (final_read_sum == load_sum) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            err_code_d = ERR_VERIFY;
          end
        end else begin
          idx_d     = idx_q + 1'b1;
          address_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered, so they follow the state being entered.
    byte_ready_d  = (state_d == S_LOAD) || (state_d == S_CHECKSUM);
    manual_read_d = (state_d == S_WRITE);
    manual_mode_d = (state_d == S_LOAD) || (state_d == S_WRITE) ||
                    (state_d == S_CHECKSUM) || (state_d == S_VERIFY);
    cpu_hold_d    = manual_mode_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      tcnt_q         <= '0;
      byte_ready_q   <= 1'b0;
      manual_mode_q  <= 1'b0;
      manual_read_q  <= 1'b0;
      address_q      <= '0;
      program_data_q <= '0;
      cpu_hold_q     <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      err_code_q     <= ERR_NONE;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      tcnt_q         <= tcnt_d;
      byte_ready_q   <= byte_ready_d;
      manual_mode_q  <= manual_mode_d;
      manual_read_q  <= manual_read_d;
      address_q      <= address_d;
      program_data_q <= program_data_d;
      cpu_hold_q     <= cpu_hold_d;
      done_q         <= done_d;
      error_q        <= error_d;
      err_code_q     <= err_code_d;
    end
  end

  assign byte_ready       = byte_ready_q;
  assign ram_manual_mode  = manual_mode_q;
  assign ram_manual_read  = manual_read_q;
  assign ram_address      = address_q;
  assign ram_program_data = program_data_q;
  assign cpu_hold         = cpu_hold_q;
  assign done             = done_q;
  assign error            = error_q;
  assign error_code       = err_code_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: RAM model, write scoreboard, table of load scenarios plus timeout/reset sequences.
module tb_ram_loader;

  localparam int WORDS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       ram_manual_mode;
  logic       ram_manual_read;
  logic [3:0] ram_address;
  logic [7:0] ram_program_data;
  logic [7:0] ram_data_in;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [1:0] error_code;

  always #5 clk = ~clk;

  ram_loader #(.WORDS(WORDS), .TIMEOUT_CYCLES(1000)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .byte_valid       (byte_valid),
    .byte_data        (byte_data),
    .byte_ready       (byte_ready),
    .ram_manual_mode  (ram_manual_mode),
    .ram_manual_read  (ram_manual_read),
    .ram_address      (ram_address),
    .ram_program_data (ram_program_data),
    .ram_data_in      (ram_data_in),
    .cpu_hold         (cpu_hold),
    .done             (done),
    .error            (error),
    .error_code       (error_code)
  );

  // Program RAM model: switch-load strobe writes, combinational readback.
  logic [7:0] mem [WORDS];
  logic       mem_clr = 1'b0;
  logic       bad_rd  = 1'b0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 8'hFF;
    end else if (ram_manual_mode && ram_manual_read) begin
      mem[ram_address] <= ram_program_data;
    end
  end

  assign ram_data_in = (bad_rd && ram_address == 4'd5) ? 8'h00 : mem[ram_address];

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] cks;
    bit         throttle;
    bit         bad5;
    bit         glitch;
    bit         exp_done;
    logic [1:0] exp_code;
    int         exp_lat;
    int         exp_vcyc;
  } vec_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   lat, vcyc, wr_pulses, stall_cnt;
  vec_t vecs[5];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int mem_bad();
    int n = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] != 8'(i + 1)) n++;
    return n;
  endfunction

  function automatic logic [19:0] out_vec();
    return {byte_ready, ram_manual_mode, ram_manual_read, ram_address, ram_program_data,
            cpu_hold, done, error, error_code};
  endfunction

  // Advance one clock and observe registered outputs just after the edge.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (ram_manual_read) begin
      wr_pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected addr=%0d data=%0h", ram_address, ram_program_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", int'(ram_address), int'(e.addr));
        check("wr_data", int'(ram_program_data), int'(e.data));
      end
    end
    if (cpu_hold && !byte_ready && !ram_manual_read) vcyc++;
  endtask

  task automatic run_load(input logic [7:0] cks, input bit throttle, input bit bad5,
                          input bit glitch, input int n_bytes, input bit rst_in_verify);
    int bi = 0;
    int c0;
    int guard = 0;
    bit acc = 1'b0;
    bit counting = 1'b0;
    bit aborted = 1'b0;
    bad_rd = bad5;
    mem_clr = !rst_in_verify;
    tick();
    mem_clr = 1'b0;
    exp_q.delete();
    wr_pulses = 0;
    vcyc = 0;
    stall_cnt = 0;
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    while (!(done || error) && guard < 3000) begin
      if (acc) begin
        byte_valid = 1'b0;
        acc = 1'b0;
      end
      if (counting && byte_ready) stall_cnt++;
      if (bi < n_bytes) begin
        if (!byte_valid) byte_valid = throttle ? ($urandom_range(0, 3) == 0) : 1'b1;
        byte_data = (bi < WORDS) ? 8'(bi + 1) : cks;
        if (byte_valid && byte_ready) begin
          if (bi < WORDS) exp_q.push_back('{addr: 4'(bi), data: 8'(bi + 1)});
          bi++;
          acc = 1'b1;
          if (bi == n_bytes && n_bytes <= WORDS) counting = 1'b1;
        end
      end
      start = glitch && bi == 5 && byte_ready;
      if (rst_in_verify && vcyc == 4) begin
        rst = 1'b1;
        byte_valid = 1'b0;
        tick();
        check("rst_verify_outputs", int'(out_vec()), 0);
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      tick();
      guard++;
    end
    start = 1'b0;
    byte_valid = 1'b0;
    lat = cyc - c0;
    if (!aborted) check("end_wait", int'(done || error), 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (3) tick();
    check("reset_outputs", int'(out_vec()), 0);
    rst = 1'b0;
    tick();
    check("idle_outputs", int'(out_vec()), 0);

    //          cks    thr   bad5  glch  done  code   lat  vcyc
    vecs[0] = '{8'h78, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 50, 16};
    vecs[1] = '{8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 34, 0};
    vecs[2] = '{8'h78, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 50, 16};
    vecs[3] = '{8'h78, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 0,  16};
    vecs[4] = '{8'h78, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 50, 16};

    for (int v = 0; v < 5; v++) begin
      run_load(vecs[v].cks, vecs[v].throttle, vecs[v].bad5, vecs[v].glitch, WORDS + 1, 1'b0);
      check($sformatf("v%0d_done", v), int'(done), int'(vecs[v].exp_done));
      check($sformatf("v%0d_error", v), int'(error), int'(!vecs[v].exp_done));
      check($sformatf("v%0d_code", v), int'(error_code), int'(vecs[v].exp_code));
      if (vecs[v].exp_lat != 0) check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("v%0d_verify_cycles", v), vcyc, vecs[v].exp_vcyc);
      check($sformatf("v%0d_write_pulses", v), wr_pulses, WORDS);
      check($sformatf("v%0d_sb_left", v), exp_q.size(), 0);
      check($sformatf("v%0d_cpu_hold", v), int'(cpu_hold), 0);
      check($sformatf("v%0d_ram_bad_words", v), mem_bad(), 0);
      tick();
      check($sformatf("v%0d_flag_sticky", v), int'(done || error), 1);
    end

    // Stream stops after three bytes: 1000 stalled LOAD cycles then TIMEOUT.
    run_load(8'h78, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    check("to_code", int'(error_code), 3);
    check("to_error", int'(error), 1);
    check("to_done", int'(done), 0);
    check("to_stall_cycles", stall_cnt, 1000);
    check("to_write_pulses", wr_pulses, 3);
    check("to_cpu_hold", int'(cpu_hold), 0);

    // Reset in the middle of VERIFY, then a fresh load with a stray start in LOAD.
    run_load(8'h78, 1'b0, 1'b0, 1'b0, WORDS + 1, 1'b1);
    tick();
    check("rst_idle_outputs", int'(out_vec()), 0);
    check("rst_ram_kept", mem_bad(), 0);
    run_load(8'h78, 1'b0, 1'b0, 1'b1, WORDS + 1, 1'b0);
    check("post_rst_done", int'(done), 1);
    check("post_rst_code", int'(error_code), 0);
    check("post_rst_latency", lat, 50);
    check("post_rst_write_pulses", wr_pulses, WORDS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
# ram_loader

Sequencer that programs the 16×8 program RAM from a byte stream, so the RAM no longer has to be loaded by hand through the DIP switches. It accepts 16 data bytes plus one checksum byte over a valid/ready handshake and writes each data byte through the RAM's manual-programming port. It then reads all 16 words back and checks them against the received data. While it runs, it holds the CPU off the bus and reports done or error.

## Interface
Parameters:
- `WORDS`, 16: number of RAM words loaded; address width is `$clog2(WORDS)`.
- `TIMEOUT_CYCLES`, 1000: maximum number of idle cycles allowed between accepted bytes while loading; 0 disables the timeout.

Ports:
- `clk`  in  1: single system clock; all logic is on its rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `start`  in  1: begin a load; sampled in IDLE, DONE and ERROR only, ignored in every other state.
- `byte_valid`  in  1: the stream source presents a byte.
- `byte_data`  in  8: stream byte.
- `byte_ready`  out  1: the loader accepts a byte this cycle.
- `ram_manual_mode`  out  1: selects the RAM's manual-programming port.
- `ram_manual_read`  out  1: RAM write strobe (switch-load strobe).
- `ram_address`  out  4: RAM address.
- `ram_program_data`  out  8: RAM write data (replaces the switch value).
- `ram_data_in`  in  8: RAM combinational read data (the RAM's `bus_out`).
- `cpu_hold`  out  1: holds the CPU (halt or clock gate) while the loader is busy.
- `done`  out  1: sticky flag; set when a load passes verification.
- `error`  out  1: sticky flag; set when a load fails.
- `error_code`  out  2: 0 NONE, 1 CHECKSUM, 2 VERIFY, 3 TIMEOUT.

## Operation
States: IDLE, LOAD, WRITE, CHECKSUM, VERIFY, DONE, ERROR.
- **IDLE, DONE, ERROR:** `start` → LOAD. On this transition the loader clears `idx`, `load_sum`, `read_sum`, the timeout counter, `done`, `error` and `error_code`.
- **LOAD:** `byte_ready`=1. On handshake (`byte_valid`&&`byte_ready`):
  - latch `byte_data` into `wdata`;
  - `load_sum += byte_data` (mod 256);
  - go to WRITE.
- **WRITE:** `byte_ready`=0, `ram_manual_read`=1, `ram_address`=`idx`, `ram_program_data`=`wdata`.
  - If `idx`==WORDS-1 → CHECKSUM.
  - Otherwise `idx`++ and go back to LOAD.
- **CHECKSUM:** `byte_ready`=1. On handshake:
  - if `(load_sum + byte_data)` mod 256 == 0 → VERIFY with `idx`=0;
  - otherwise → ERROR with code CHECKSUM.
  - The checksum byte is never written to the RAM.
- **VERIFY:** `ram_address`=`idx`, `read_sum += ram_data_in`. At `idx`==WORDS-1:
  - → DONE if `(read_sum + ram_data_in)` == `load_sum`;
  - otherwise → ERROR with code VERIFY.
- **Timeout:** the counter runs in LOAD and CHECKSUM on every cycle without a handshake, and clears on each handshake. When the count reaches `TIMEOUT_CYCLES`, the loader goes to ERROR with code TIMEOUT.
- **Outputs in active states:**
  - `ram_manual_mode`=1 and `cpu_hold`=1 in LOAD, WRITE, CHECKSUM and VERIFY;
  - `ram_manual_read` is asserted only in WRITE.
- **Outputs elsewhere:** `ram_address`=0 and `ram_program_data`=0 outside WRITE and VERIFY.
- **Arithmetic:** all sums are 8-bit and wrap mod 256. `idx` never wraps past WORDS-1.

## Timing
- **Reset value of every output:** state=IDLE, and every output is 0 (`byte_ready`, `ram_manual_mode`, `ram_manual_read`, `ram_address`, `ram_program_data`, `cpu_hold`, `done`, `error`, `error_code`).
- **Start:** `start` high at edge N → LOAD from cycle N+1, with `byte_ready`=1 in that same cycle.
- **Write timing:** a handshake at edge N → WRITE during cycle N+1; the RAM captures the data at edge N+2.
- **Throughput:** at most one data byte per 2 cycles.
- **Best-case latency** from `start` to `done`: 1 + 2·WORDS + 1 + WORDS cycles, i.e. 50 cycles for WORDS=16.
- **Flags:** `done` and `error` rise in the first cycle of DONE or ERROR.
- **Reset mid-operation:** the loader returns to IDLE on the next edge and releases `cpu_hold`. RAM words already written keep their values.
- **Ignored `start`:** a `start` pulse in LOAD, WRITE, CHECKSUM or VERIFY has no effect.
- **Timeout counter:** saturates; it does not wrap.

## Structure
- **Package `ram_loader_pkg`:** holds
  - the `state_t` enum;
  - the `error_code_t` enum (NONE, CHECKSUM, VERIFY, TIMEOUT);
  - `RAM_WORDS`=16 and `RAM_DATA_W`=8, shared with `random_access_memory` and the top level.
- **Sub-module `byte_checksum`:** an 8-bit modular accumulator with clear and add-enable. It is instantiated twice, once for `load_sum` and once for `read_sum`.
- **Timeout counter:** inline in `ram_loader`.

## Test plan
- **Clean load:** stream bytes 0x01..0x10, then 0x78 (the 16 bytes sum to 0x88). Required response:
  - RAM[i]=i+1;
  - `done`=1 and `error_code`=0 exactly 50 cycles after `start`;
  - `cpu_hold` returns to 0.
- **Bad checksum:** stream the same data with checksum 0x77. Required response:
  - `error`=1 and `error_code`=1;
  - no VERIFY cycles occur;
  - RAM[0..15] still hold 0x01..0x10.
- **Verify failure:** the bench RAM model forces readback of address 5 to 0x00. Required response: `error_code`=2 one cycle after VERIFY of address 15.
- **Throttled source:** randomise `byte_valid` gaps shorter than TIMEOUT. Required response:
  - exactly one `ram_manual_read` pulse per accepted data byte;
  - never more than 16 pulses;
  - `done`=1.
- **Timeout:** with TIMEOUT_CYCLES=1000, stop the stream after 3 bytes. Required response: `error_code`=3 after 1000 stalled cycles in LOAD.
- **Reset and ignored start:**
  - assert `rst` during VERIFY → all outputs 0 on the next cycle;
  - a new `start` followed by a clean stream → `done`=1;
  - a `start` pulse during LOAD → ignored.
